// File: rtl/noise_pkg.sv
// Shared widths and FSM state encoding for the noise statistics block.
package noise_pkg;

    localparam int SAMPLE_W = 24;
    localparam int MAX_LOG2 = 16;
    localparam int SUM_W    = SAMPLE_W + MAX_LOG2;
    localparam int SQ_W     = 2*SAMPLE_W + MAX_LOG2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/noise_sq.sv
// Registered signed squarer: one pipeline stage between the sample and its square.
module noise_sq import noise_pkg::*; #(
    parameter int W = SAMPLE_W
) (
    input  logic                CK,
    input  logic                RB,
    input  logic signed [W-1:0] x_i,
    output logic [2*W-1:0]      sq_o
);

    logic signed [2*W-1:0] x_ext;
    logic signed [2*W-1:0] prod;
    logic [2*W-1:0]        sq_q;

    assign x_ext = (2*W)'(x_i);
    assign prod  = x_ext * x_ext;

    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            sq_q <= '0;
        end else begin
            sq_q <= $unsigned(prod);
        end
    end

    assign sq_o = sq_q;

endmodule

// File: rtl/noise_stats.sv
// Block statistics (sum, sum of squares, mean, extremes) over 2^n_log2 noise samples.
//   state | meaning
//   IDLE  | no block armed, results hold
//   RUN   | accepting samples until N have been taken
//   FLUSH | last square drains into sumsq, samples ignored
//   DONE  | results valid and held
module noise_stats #(
    parameter int SAMPLE_W = noise_pkg::SAMPLE_W,
    parameter int MAX_LOG2 = noise_pkg::MAX_LOG2
) (
    input  logic                                  CK,
    input  logic                                  RB,
    input  logic                                  ST,
    input  logic [4:0]                            n_log2,
    input  logic                                  in_valid,
    input  logic signed [SAMPLE_W-1:0]            C,
    output logic                                  busy,
    output logic                                  done,
    output logic signed [SAMPLE_W+MAX_LOG2-1:0]   sum,
    output logic [2*SAMPLE_W+MAX_LOG2-1:0]        sumsq,
    output logic signed [SAMPLE_W-1:0]            mean,
    output logic signed [SAMPLE_W-1:0]            min_s,
    output logic signed [SAMPLE_W-1:0]            max_s,
    output logic [MAX_LOG2:0]                     count
);

    import noise_pkg::state_t;
    import noise_pkg::IDLE;
    import noise_pkg::RUN;
    import noise_pkg::FLUSH;
    import noise_pkg::DONE;

    localparam int SUM_W = SAMPLE_W + MAX_LOG2;
    localparam int SQ_W  = 2*SAMPLE_W + MAX_LOG2;
    localparam int CNT_W = MAX_LOG2 + 1;

    localparam logic signed [SAMPLE_W-1:0] POS_FS = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] NEG_FS = {1'b1, {(SAMPLE_W-1){1'b0}}};

    state_t                      state_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        sq_vld_q;
    logic [4:0]                  nlog_q;
    logic signed [SUM_W-1:0]     sum_q;
    logic [SQ_W-1:0]             sumsq_q;
    logic signed [SAMPLE_W-1:0]  min_q;
    logic signed [SAMPLE_W-1:0]  max_q;
    logic [CNT_W-1:0]            count_q;

    logic [2*SAMPLE_W-1:0]       sq;
    logic [4:0]                  nlog_sat;
    logic [CNT_W-1:0]            blk_len;
    logic [CNT_W-1:0]            count_d;
    logic signed [SUM_W-1:0]     sum_d;
    logic [SQ_W-1:0]             sumsq_d;
    logic                        accept;
    logic                        last;

    noise_sq #(
        .W (SAMPLE_W)
    ) u_sq (
        .CK   (CK),
        .RB   (RB),
        .x_i  (C),
        .sq_o (sq)
    );

    assign nlog_sat = (n_log2 > 5'(MAX_LOG2)) ? 5'(MAX_LOG2) : n_log2;
    assign blk_len  = CNT_W'(1) << nlog_q;

    // ST has priority over a coincident sample, so a restart never counts it.
    assign accept   = (state_q == RUN) && in_valid && !ST;
    assign count_d  = count_q + CNT_W'(1);
    assign last     = accept && (count_d == blk_len);
    assign sum_d    = sum_q + SUM_W'(C);
    assign sumsq_d  = sumsq_q + SQ_W'(sq);

    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sq_vld_q <= 1'b0;
            nlog_q   <= '0;
            sum_q    <= '0;
            sumsq_q  <= '0;
            min_q    <= '0;
            max_q    <= '0;
            count_q  <= '0;
        end else if (ST) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            sq_vld_q <= 1'b0;
            nlog_q   <= nlog_sat;
            sum_q    <= '0;
            sumsq_q  <= '0;
            min_q    <= POS_FS;
            max_q    <= NEG_FS;
            count_q  <= '0;
        end else begin
            // The squarer output trails acceptance by one edge.
            sq_vld_q <= accept;
            if (sq_vld_q) begin
                sumsq_q <= sumsq_d;
            end
            if (accept) begin
                sum_q   <= sum_d;
                count_q <= count_d;
                if (C < min_q) begin
                    min_q <= C;
                end
                if (C > max_q) begin
                    max_q <= C;
                end
            end
            case (state_q)
                RUN: begin
                    if (last) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign sumsq = sumsq_q;
    assign min_s = min_q;
    assign max_s = max_q;
    assign count = count_q;
    assign mean  = SAMPLE_W'(sum_q >>> nlog_q);

endmodule

// File: tb/tb_noise_stats.sv
// Bench for noise_stats: directed corner blocks plus random blocks against a sample-level model.
module tb_noise_stats;

    localparam int     SW     = 24;
    localparam int     ML     = 16;
    localparam longint POS_FS = 64'sd8388607;
    localparam longint NEG_FS = -64'sd8388608;

    logic                   CK       = 1'b0;
    logic                   RB       = 1'b0;
    logic                   ST       = 1'b0;
    logic [4:0]             n_log2   = '0;
    logic                   in_valid = 1'b0;
    logic signed [SW-1:0]   C        = '0;
    logic                   busy;
    logic                   done;
    logic signed [SW+ML-1:0] sum;
    logic [2*SW+ML-1:0]     sumsq;
    logic signed [SW-1:0]   mean;
    logic signed [SW-1:0]   min_s;
    logic signed [SW-1:0]   max_s;
    logic [ML:0]            count;

    int n_cmp = 0;
    int n_bad = 0;
    string phase = "init";

    // Model: aggregates of the samples accepted in the current block.
    longint m_sum, m_sq, m_pend, m_min, m_max;
    int     m_cnt, m_n;
    bit     m_active, m_tail, m_done;

    noise_stats #(.SAMPLE_W(SW), .MAX_LOG2(ML)) dut (
        .CK       (CK),
        .RB       (RB),
        .ST       (ST),
        .n_log2   (n_log2),
        .in_valid (in_valid),
        .C        (C),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .sumsq    (sumsq),
        .mean     (mean),
        .min_s    (min_s),
        .max_s    (max_s),
        .count    (count)
    );

    always #5 CK = ~CK;

    task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    function automatic logic [63:0] exp_mean();
        longint d, q;
        logic signed [SW-1:0] q24;
        d = longint'(1) << m_n;
        q = m_sum / d;
        if ((m_sum % d != 0) && (m_sum < 0)) q = q - 1;
        q24 = q[SW-1:0];
        return 64'(q24);
    endfunction

    task automatic check_all(input string tag);
        cmp({tag, ".busy"},  64'(busy),  64'(m_active || m_tail));
        cmp({tag, ".done"},  64'(done),  64'(m_done));
        cmp({tag, ".sum"},   64'(sum),   m_sum);
        cmp({tag, ".sumsq"}, 64'(sumsq), m_sq - m_pend);
        cmp({tag, ".mean"},  64'(mean),  exp_mean());
        cmp({tag, ".min"},   64'(min_s), m_min);
        cmp({tag, ".max"},   64'(max_s), m_max);
        cmp({tag, ".count"}, 64'(count), 64'(m_cnt));
    endtask

    task automatic model_reset();
        m_sum = 0; m_sq = 0; m_pend = 0; m_min = 0; m_max = 0;
        m_cnt = 0; m_n = 0;
        m_active = 0; m_tail = 0; m_done = 0;
    endtask

    task automatic model_step(input bit st, input logic [4:0] nl, input bit v, input longint c);
        m_pend = 0;
        if (st) begin
            m_n = (int'(nl) > ML) ? ML : int'(nl);
            m_sum = 0; m_sq = 0; m_cnt = 0;
            m_min = POS_FS; m_max = NEG_FS;
            m_active = 1; m_tail = 0; m_done = 0;
        end else if (m_tail) begin
            m_tail = 0;
            m_done = 1;
        end else if (m_active && v) begin
            m_sum += c;
            m_sq  += c * c;
            m_pend = c * c;
            m_cnt++;
            if (c < m_min) m_min = c;
            if (c > m_max) m_max = c;
            if (m_cnt == (1 << m_n)) begin
                m_active = 0;
                m_tail   = 1;
            end
        end
    endtask

    task automatic step(input bit st, input logic [4:0] nl, input bit v, input longint c, input bit chk);
        ST = st; n_log2 = nl; in_valid = v; C = SW'(c);
        model_step(st, nl, v, c);
        @(posedge CK); #1;
        ST = 1'b0; in_valid = 1'b0;
        if (chk) check_all(phase);
    endtask

    task automatic pulse_reset();
        #2 RB = 1'b0;
        #1;
        model_reset();
        check_all({phase, ".rst"});
        @(posedge CK); #1;
        RB = 1'b1;
        check_all({phase, ".rel"});
    endtask

    function automatic longint rnd_sample();
        logic signed [SW-1:0] r;
        case ($urandom_range(0, 7))
            0:       r = {1'b1, {(SW-1){1'b0}}};
            1:       r = {1'b0, {(SW-1){1'b1}}};
            default: r = SW'($urandom);
        endcase
        return longint'(r);
    endfunction

    initial begin
        int  nl;
        bit  v;
        bit  ab;

        model_reset();
        repeat (2) @(posedge CK);
        #1;
        phase = "por";
        check_all(phase);
        RB = 1'b1;
        step(0, 0, 1, 123, 1);

        // Small known block: 5, -3, 7, 1 with N=4.
        phase = "basic";
        step(1, 2, 0, 0, 1);
        step(0, 2, 1, 5, 1);
        step(0, 2, 1, -3, 1);
        step(0, 2, 1, 7, 1);
        step(0, 2, 1, 1, 1);
        cmp("basic.flush_done", 64'(done), 64'(0));
        step(0, 2, 1, 99, 1);
        cmp("basic.done",  64'(done),  64'(1));
        cmp("basic.sum",   64'(sum),   64'(10));
        cmp("basic.sumsq", 64'(sumsq), 64'(84));
        cmp("basic.mean",  64'(mean),  64'(2));
        cmp("basic.min",   64'(min_s), -64'sd3);
        cmp("basic.max",   64'(max_s), 64'(7));
        cmp("basic.count", 64'(count), 64'(4));
        step(0, 2, 1, 55, 1);
        step(0, 2, 1, -55, 1);

        // N=1 with the most negative sample.
        phase = "n1";
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, NEG_FS, 1);
        step(0, 0, 1, 17, 1);
        cmp("n1.done",  64'(done),  64'(1));
        cmp("n1.sum",   64'(sum),   NEG_FS);
        cmp("n1.sumsq", 64'(sumsq), 64'(1) << 46);
        cmp("n1.mean",  64'(mean),  NEG_FS);

        // Toggled valid, restart after 5 samples, then a complete block.
        phase = "abort";
        step(1, 3, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(0, 3, (i % 2) == 0, rnd_sample(), 1);
        cmp("abort.pre_cnt", 64'(count), 64'(5));
        step(1, 3, 1, rnd_sample(), 1);
        cmp("abort.cnt",  64'(count), 64'(0));
        cmp("abort.done", 64'(done),  64'(0));
        for (int i = 0; i < 9; i++) step(0, 3, 1, rnd_sample(), 1);
        cmp("abort.final_done", 64'(done), 64'(1));

        // Reset in the middle of a block, then a fresh block.
        phase = "reset";
        step(1, 2, 0, 0, 1);
        step(0, 2, 1, 1000, 1);
        step(0, 2, 1, -2000, 1);
        pulse_reset();
        step(0, 2, 1, 3333, 1);
        step(1, 2, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 2, 1, rnd_sample(), 1);
        cmp("reset.final_done", 64'(done), 64'(1));

        // ST coincident with the last sample.
        phase = "st_last";
        step(1, 2, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 2, 1, rnd_sample(), 1);
        step(1, 2, 1, rnd_sample(), 1);
        cmp("st_last.cnt",  64'(count), 64'(0));
        cmp("st_last.done", 64'(done),  64'(0));
        for (int i = 0; i < 5; i++) step(0, 2, 1, rnd_sample(), 1);

        // Random blocks with sparse valid and occasional aborts.
        phase = "rand";
        for (int b = 0; b < 14; b++) begin
            nl = $urandom_range(0, 5);
            if (b == 3) nl = 20;
            step(1, 5'(nl), 0, 0, 1);
            for (int k = 0; k < 200 && !m_done; k++) begin
                v  = ($urandom_range(0, 3) != 0);
                ab = ($urandom_range(0, 59) == 0);
                step(ab, 5'($urandom_range(0, 5)), v, rnd_sample(), 1);
            end
            repeat (2) step(0, 0, 1, rnd_sample(), 1);
        end

        // Largest block at positive full scale.
        phase = "full";
        step(1, 16, 0, 0, 1);
        for (int i = 0; i < 65536; i++) step(0, 16, 1, POS_FS, (i < 2) || ((i % 4096) == 4095));
        step(0, 16, 0, 0, 1);
        cmp("full.done",  64'(done),  64'(1));
        cmp("full.sum",   64'(sum),   POS_FS * 65536);
        cmp("full.mean",  64'(mean),  POS_FS);
        cmp("full.count", 64'(count), 64'(65536));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
